// File: rtl/riscv_ring_link.sv
// ---------------------------------------------------------------------------
// riscv_ring_link : per-channel ring-link flit FIFOs, cut-through or store-and-forward
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module riscv_ring_link #(
   parameter int FLIT_WIDTH = 16,
   parameter int CHANNELS   = 2,
   parameter int DEPTH      = 4,
   parameter int MODE       = 0
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]        in_data,
   input  logic [CHANNELS-1:0]                        in_last,
   input  logic [CHANNELS-1:0]                        in_valid,
   output logic [CHANNELS-1:0]                        in_ready,
   output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]        out_data,
   output logic [CHANNELS-1:0]                        out_last,
   output logic [CHANNELS-1:0]                        out_valid,
   input  logic [CHANNELS-1:0]                        out_ready,
   output logic [CHANNELS-1:0][$clog2(DEPTH+1)-1:0]   fill,
   output logic [CHANNELS-1:0][$clog2(DEPTH+1)-1:0]   pkts
);

   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam int c_ptr_w = $clog2(DEPTH);
   localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
      logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
      logic [c_cnt_w-1:0]  fill_q, fill_d;
      logic [c_cnt_w-1:0]  pkts_q, pkts_d;
      logic [FLIT_WIDTH:0] mem_q [DEPTH];
      logic [FLIT_WIDTH:0] head;
      logic                valid;
      logic                push;
      logic                pop;
      logic                last_in;
      logic                last_out;

      always_comb begin
         head     = mem_q[rd_ptr_q];
         // store-and-forward still releases a full FIFO so over-long packets cannot deadlock
         if (MODE == 0) begin
            valid = (fill_q != '0);
         end else begin
            valid = (pkts_q != '0) || (fill_q == c_full);
         end
         push     = in_valid[c] && (fill_q != c_full);
         pop      = valid && out_ready[c];
         last_in  = push && in_last[c];
         last_out = pop && head[FLIT_WIDTH];

         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         fill_d   = fill_q;
         pkts_d   = pkts_q;

         if (push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
         end

         case ({push, pop})
            2'b10:   fill_d = fill_q + c_cnt_w'(1);
            2'b01:   fill_d = fill_q - c_cnt_w'(1);
            default: fill_d = fill_q;
         endcase

         case ({last_in, last_out})
            2'b10:   pkts_d = pkts_q + c_cnt_w'(1);
            2'b01:   pkts_d = pkts_q - c_cnt_w'(1);
            default: pkts_d = pkts_q;
         endcase
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            pkts_q   <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            pkts_q   <= pkts_d;
         end
      end

      // storage is never reset; stale entries are masked by the counters
      always_ff @(posedge clk) begin
         if (push) begin
            mem_q[wr_ptr_q] <= {in_last[c], in_data[c]};
         end
      end

      assign in_ready[c]  = (fill_q != c_full);
      assign out_valid[c] = valid;
      assign out_data[c]  = valid ? head[FLIT_WIDTH-1:0] : '0;
      assign out_last[c]  = valid & head[FLIT_WIDTH];
      assign fill[c]      = fill_q;
      assign pkts[c]      = pkts_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_riscv_ring_link.sv
// ---------------------------------------------------------------------------
// tb_riscv_ring_link : checks both link modes against a queue-based flit model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_riscv_ring_link;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [1:0][15:0]      in_data;
   logic [1:0]            in_last;
   logic [1:0]            in_valid;
   logic [1:0]            out_ready;

   logic [1:0]            in_ready_o  [2];
   logic [1:0][15:0]      out_data_o  [2];
   logic [1:0]            out_last_o  [2];
   logic [1:0]            out_valid_o [2];
   logic [1:0][2:0]       fill_o      [2];
   logic [1:0][2:0]       pkts_o      [2];

   int n_cmp = 0;
   int n_err = 0;

   // model: one flit queue per (mode, channel), index = mode*2 + channel
   logic [16:0] mq [4][$];

   always #5 clk = ~clk;

   for (genvar m = 0; m < 2; m++) begin : g_dut
      riscv_ring_link #(
         .FLIT_WIDTH (16),
         .CHANNELS   (2),
         .DEPTH      (4),
         .MODE       (m)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_data   (in_data),
         .in_last   (in_last),
         .in_valid  (in_valid),
         .in_ready  (in_ready_o[m]),
         .out_data  (out_data_o[m]),
         .out_last  (out_last_o[m]),
         .out_valid (out_valid_o[m]),
         .out_ready (out_ready),
         .fill      (fill_o[m]),
         .pkts      (pkts_o[m])
      );
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int n_lasts(input int k);
      int n = 0;
      foreach (mq[k][i]) if (mq[k][i][16]) n++;
      return n;
   endfunction

   function automatic bit exp_valid(input int k);
      if (mq[k].size() == 0) return 1'b0;
      if (k / 2 == 0)        return 1'b1;
      return (n_lasts(k) > 0) || (mq[k].size() == 4);
   endfunction

   task automatic check_all();
      for (int k = 0; k < 4; k++) begin
         int          m  = k / 2;
         int          c  = k % 2;
         bit          ev = exp_valid(k);
         logic [16:0] hd = ev ? mq[k][0] : 17'h0;
         chk($sformatf("m%0d_c%0d_in_ready", m, c), 32'(in_ready_o[m][c]), 32'(mq[k].size() < 4));
         chk($sformatf("m%0d_c%0d_out_valid", m, c), 32'(out_valid_o[m][c]), 32'(ev));
         chk($sformatf("m%0d_c%0d_out_data", m, c), 32'(out_data_o[m][c]), 32'(hd[15:0]));
         chk($sformatf("m%0d_c%0d_out_last", m, c), 32'(out_last_o[m][c]), 32'(hd[16]));
         chk($sformatf("m%0d_c%0d_fill", m, c), 32'(fill_o[m][c]), 32'(mq[k].size()));
         chk($sformatf("m%0d_c%0d_pkts", m, c), 32'(pkts_o[m][c]), 32'(n_lasts(k)));
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < 4; k++) mq[k].delete();
   endtask

   // one clock: predict pushes/pops from pre-edge state, advance, then compare
   task automatic tick();
      bit pu [4];
      bit po [4];
      for (int k = 0; k < 4; k++) begin
         int c = k % 2;
         pu[k] = !rst && in_valid[c] && (mq[k].size() < 4);
         po[k] = !rst && exp_valid(k) && out_ready[c];
      end
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         int c = k % 2;
         if (po[k]) void'(mq[k].pop_front());
         if (pu[k]) mq[k].push_back({in_last[k % 2], in_data[c]});
      end
      #1;
      check_all();
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_last   = '0;
      in_valid  = '0;
      out_ready = '0;
      clear_model();
      #1;
      check_all();
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;

      // single flit with last on ch0
      in_valid = 2'b01; in_data[0] = 16'h1111; in_last[0] = 1'b1;
      tick();
      chk("first_flit_data", 32'(out_data_o[0][0]), 32'h1111);
      chk("first_flit_ch1_idle", 32'(out_valid_o[0][1]), 32'h0);
      in_valid = '0; in_last = '0; out_ready = 2'b11;
      tick();

      // fill to capacity with the fifth flit held upstream
      out_ready = '0; in_valid = 2'b01;
      for (int i = 0; i < 5; i++) begin
         in_data[0] = 16'h00A0 + 16'(i);
         tick();
         if (i == 3) chk("full_in_ready", 32'(in_ready_o[0][0]), 32'h0);
      end
      out_ready = 2'b01;
      tick();
      chk("full_pop_no_push", 32'(fill_o[0][0]), 32'h3);
      tick();
      in_valid = '0;
      for (int i = 0; i < 4; i++) tick();
      in_valid = 2'b01; in_data[0] = 16'h00AF; in_last[0] = 1'b1;
      tick();
      in_valid = '0; in_last = '0;
      for (int i = 0; i < 6; i++) tick();

      // store-and-forward holds a packet until its last flit arrives
      out_ready = '0; in_valid = 2'b01;
      for (int i = 0; i < 3; i++) begin
         in_data[0] = 16'h0C00 + 16'(i);
         in_last[0] = (i == 2);
         tick();
         chk($sformatf("saf_valid_%0d", i), 32'(out_valid_o[1][0]), 32'(i == 2));
      end
      chk("saf_pkts", 32'(pkts_o[1][0]), 32'h1);
      in_valid = '0; in_last = '0; out_ready = 2'b11;
      for (int i = 0; i < 4; i++) tick();

      // asynchronous reset mid-packet
      out_ready = '0; in_valid = 2'b01;
      for (int i = 0; i < 3; i++) begin
         in_data[0] = 16'h0D00 + 16'(i);
         tick();
      end
      in_valid = '0;
      #2;
      rst = 1'b1;
      #1;
      clear_model();
      chk("async_rst_fill", 32'(fill_o[0][0]), 32'h0);
      chk("async_rst_valid", 32'(out_valid_o[1][0]), 32'h0);
      check_all();
      @(negedge clk);
      rst = 1'b0;
      in_valid = 2'b01; in_data[0] = 16'hBEEF; in_last[0] = 1'b1;
      tick();
      chk("post_rst_data", 32'(out_data_o[0][0]), 32'hBEEF);
      in_valid = '0; in_last = '0; out_ready = 2'b11;
      tick();

      // random traffic; a stalled upstream flit is held stable
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < 2; c++) begin
            bit stalled = in_valid[c] && ((mq[c].size() == 4) || (mq[2 + c].size() == 4));
            if (!stalled) begin
               in_valid[c] = ($urandom_range(0, 3) != 0);
               in_data[c]  = 16'($urandom);
               in_last[c]  = ($urandom_range(0, 2) == 0);
            end
            out_ready[c] = ($urandom_range(0, 2) != 0);
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/riscv_ring_link.md
RISCV_RING_LINK -- requirements
Module: riscv_ring_link

Interface
REQ-001 Parameter FLIT_WIDTH, default 16, data bits per flit.
REQ-002 Parameter CHANNELS, default 2, number of independent ring channels.
REQ-003 Parameter DEPTH, default 4, entries per channel FIFO; power of two, >=2.
REQ-004 Parameter MODE, default 0; 0 = cut-through, 1 = store-and-forward.
REQ-005 Port clk, input, 1 bit. The block uses one clock.
REQ-006 Port rst, input, 1 bit. Reset is asynchronous and active-high.
REQ-007 Port in_data, input, [CHANNELS][FLIT_WIDTH], upstream flit data.
REQ-008 Port in_last, input, [CHANNELS], upstream end-of-packet marker.
REQ-009 Port in_valid, input, [CHANNELS], upstream flit valid.
REQ-010 Port in_ready, output, [CHANNELS], space available.
REQ-011 Port out_data, output, [CHANNELS][FLIT_WIDTH], head flit data.
REQ-012 Port out_last, output, [CHANNELS], head flit end-of-packet marker.
REQ-013 Port out_valid, output, [CHANNELS], head flit presentable.
REQ-014 Port out_ready, input, [CHANNELS], downstream accept.
REQ-015 Port fill, output, [CHANNELS][$clog2(DEPTH+1)], current entry count.
REQ-016 Port pkts, output, [CHANNELS][$clog2(DEPTH+1)], count of stored flits with last=1.

Function
REQ-017 Channels SHALL be fully independent; no arbitration and no shared state.
REQ-018 in_ready[c] SHALL equal (fill[c] < DEPTH), derived from registers only and independent of out_ready.
REQ-019 A push SHALL occur on a rising clk edge with in_valid[c] && in_ready[c]; data and last are written at the write pointer.
REQ-020 A pop SHALL occur on a rising clk edge with out_valid[c] && out_ready[c]; the read pointer advances.
REQ-021 Write and read pointers SHALL wrap modulo DEPTH.
REQ-022 fill SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-023 When the FIFO is full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-024 pkts SHALL update as follows: +1 on push with in_last=1, -1 on pop with out_last=1, unchanged when both occur together.
REQ-025 In MODE 0, out_valid[c] SHALL equal (fill[c] > 0).
REQ-026 In MODE 1, out_valid[c] SHALL equal (pkts[c] > 0) || (fill[c] == DEPTH). The full-FIFO term prevents deadlock on packets longer than DEPTH.
REQ-027 Latency: a flit pushed at edge N SHALL appear on out_* after edge N, i.e. one cycle, when the FIFO was empty. There is no combinational in-to-out path.
REQ-028 out_data and out_last SHALL be driven to 0 whenever out_valid is 0.
REQ-029 Once asserted, out_valid SHALL stay asserted with stable out_data and out_last until popped.
REQ-030 Flit order within a channel SHALL be preserved exactly.
REQ-031 Behaviour is undefined when in_data or in_last change while in_valid=1 and in_ready=0; this case is flagged by a bench assertion only.

Reset
REQ-032 While rst=1, pointers, fill and pkts SHALL be 0, out_valid=0, out_data=0, out_last=0, and in_ready all 1.
REQ-033 Assertion of rst mid-packet SHALL discard all stored flits immediately. No partial packet SHALL be emitted after deassertion.
REQ-034 FIFO storage SHALL NOT require reset.

Verification (FLIT_WIDTH=16, CHANNELS=2, DEPTH=4)
REQ-035 MODE 0: push 0x1111 with last=1 on ch0 at edge 1 -> out_valid[0]=1 and out_data[0]=0x1111 after edge 1; fill[0]=1; ch1 out_valid stays 0.
REQ-036 MODE 0: hold out_ready=0 and push 5 flits 0xA0..0xA4 -> in_ready[0]=0 after the 4th push; 0xA4 is held upstream. Then set out_ready=1 -> output sequence is 0xA0,0xA1,0xA2,0xA3,0xA4.
REQ-037 Full FIFO with out_ready=1 and in_valid=1 in the same cycle -> one pop, no push; fill goes 4 to 3, and the push completes on the next edge.
REQ-038 MODE 1: push 3 flits with last=0,0,1 -> out_valid=0 until the edge accepting the last flit; then pkts=1 and 3 flits drain in order.
REQ-039 MODE 1: push 4 flits with last=0 -> out_valid asserts at fill=4. Popping one flit deasserts out_valid; after the next push, out_valid reasserts.
REQ-040 Assert rst asynchronously with fill=3 mid-packet -> fill, pkts and out_valid go to 0 without a clock edge; after release the first new push emerges unaffected.
